// File: rtl/ula_registro_resultado.sv
`default_nettype none
// ============================================================================
// Module   : ula_registro_resultado
// Brief    : Result stage for the 4-bit ripple adder. Computes N/Z/C/V at
//            capture time and buffers {sum, flags} in a 2-entry valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ula_registro_resultado #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             limpar,
  input  logic [3:0]       in_soma,
  input  logic             in_cout,
  input  logic             in_a3,
  input  logic             in_b3,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_res,
  output logic [3:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count,
  output logic             full
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t             r_state;
  occ_t             w_state_nxt;
  logic [7:0]       r_mem [DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_op_count;
  logic [3:0]       w_flags;
  logic             w_push;
  logic             w_pop;

  // Overflow: operands share a sign but the sum's sign differs from it.
  assign w_flags = {in_soma[3],
                    (in_soma == 4'd0),
                    in_cout,
                    (in_a3 == in_b3) && (in_soma[3] != in_a3)};

  assign in_ready  = (r_state != S_FULL);
  assign full      = (r_state == S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_res   = out_valid ? r_mem[r_rd_ptr][7:4] : 4'd0;
  assign out_flags = out_valid ? r_mem[r_rd_ptr][3:0] : 4'd0;
  assign op_count  = r_op_count;

  always_comb begin
    w_state_nxt = r_state;
    if (limpar) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = S_FULL;
          else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_pop) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_op_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (limpar) begin
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
        r_op_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= {in_soma, w_flags};
          r_wr_ptr        <= ~r_wr_ptr;
          r_op_count      <= r_op_count + CNT_W'(1);
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_registro_resultado.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_registro_resultado
// Brief    : Directed and random checks of the result FIFO against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_registro_resultado;

  logic       clk = 1'b0;
  logic       rst_n, limpar, in_cout, in_a3, in_b3, in_valid, out_ready;
  logic [3:0] in_soma;
  logic       in_ready, out_valid, full;
  logic [3:0] out_res, out_flags;
  logic [7:0] op_count;

  ula_registro_resultado #(.CNT_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .limpar(limpar),
    .in_soma(in_soma), .in_cout(in_cout), .in_a3(in_a3), .in_b3(in_b3),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_res(out_res), .out_flags(out_flags), .out_valid(out_valid),
    .out_ready(out_ready), .op_count(op_count), .full(full)
  );

  always #5 clk = ~clk;

  logic [7:0]  q[$];
  int unsigned m_cnt;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [3:0] ref_flags(input logic [3:0] s, input logic c,
                                           input logic a3, input logic b3);
    logic n, z, v;
    n = (s >= 4'd8);
    z = (s == 4'd0);
    v = (a3 == b3) && (n != a3);
    return {n, z, c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_res",   32'(out_res),   32'(q.size() != 0 ? q[0][7:4] : 4'd0));
    chk("out_flags", 32'(out_flags), 32'(q.size() != 0 ? q[0][3:0] : 4'd0));
    chk("full",      32'(full),      32'(q.size() == 2));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
    chk("op_count",  32'(op_count),  m_cnt);
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic c,
                       input logic a, input logic b, input logic r, input logic l);
    in_valid = v; in_soma = s; in_cout = c; in_a3 = a; in_b3 = b;
    out_ready = r; limpar = l;
  endtask

  // Advance one clock, update the model from what was presented, then check.
  task automatic tick();
    bit push, pop, clr;
    logic [7:0] entry;
    push  = in_valid && (q.size() < 2);
    pop   = out_ready && (q.size() > 0);
    clr   = limpar;
    entry = {in_soma, ref_flags(in_soma, in_cout, in_a3, in_b3)};
    @(posedge clk); #1;
    if (clr) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(entry);
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    check_all();
  endtask

  initial begin
    m_cnt = 0;
    drive(0, 4'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_all();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 7+1: N and V set
    drive(1, 4'b1000, 0, 0, 0, 0, 0); tick();
    chk("t1_res", 32'(out_res), 32'd8);
    chk("t1_flags", 32'(out_flags), 32'b1001);
    chk("t1_cnt", 32'(op_count), 32'd1);

    // 8+8: Z, C, V; head 8 popped while 0 pushed
    drive(1, 4'd0, 1, 1, 1, 1, 0); tick();
    chk("t2_res", 32'(out_res), 32'd0);
    chk("t2_flags", 32'(out_flags), 32'b0111);
    drive(0, 4'd0, 0, 0, 0, 1, 0); tick();
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Back-to-back into a stalled consumer
    drive(0, 4'd0, 0, 0, 0, 0, 1); tick();
    drive(1, 4'd3, 0, 0, 0, 0, 0); tick();
    drive(1, 4'd5, 0, 0, 0, 0, 0); tick();
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    drive(1, 4'd9, 0, 0, 0, 0, 0); tick();
    chk("t3_held_cnt", 32'(op_count), 32'd2);
    chk("t3_head3", 32'(out_res), 32'd3);
    drive(1, 4'd9, 0, 0, 0, 1, 0); tick();
    chk("t3_head5", 32'(out_res), 32'd5);
    drive(1, 4'd9, 0, 0, 0, 1, 0); tick();
    chk("t3_head9", 32'(out_res), 32'd9);
    chk("t4_cnt", 32'(op_count), 32'd3);
    chk("t4_one", 32'(full), 32'd0);
    drive(0, 4'd0, 0, 0, 0, 1, 0); tick();

    // Counter wrap after 256 accepted pushes
    drive(0, 4'd0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 256; i++) begin
      drive(1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
      tick();
    end
    chk("t5_wrap", 32'(op_count), 32'd0);
    drive(0, 4'd0, 0, 0, 0, 1, 0); tick();

    // Clear while full with a coincident push attempt
    drive(1, 4'd6, 0, 0, 0, 0, 0); tick();
    drive(1, 4'd7, 0, 0, 0, 0, 0); tick();
    chk("t6_full", 32'(full), 32'd1);
    drive(1, 4'd2, 0, 0, 0, 0, 1); tick();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_cnt", 32'(op_count), 32'd0);
    // Clear with push while empty: push must not be counted
    drive(1, 4'd4, 0, 0, 0, 0, 1); tick();
    chk("t6b_cnt", 32'(op_count), 32'd0);

    // Asynchronous reset while full
    drive(1, 4'd10, 0, 0, 0, 0, 0); tick();
    drive(1, 4'd11, 0, 0, 0, 0, 0); tick();
    rst_n = 1'b0;
    #2;
    q.delete(); m_cnt = 0;
    chk("t7_res", 32'(out_res), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4'd1, 0, 0, 0, 0, 0); tick();
    chk("t7_res1", 32'(out_res), 32'd1);
    chk("t7_cnt", 32'(op_count), 32'd1);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 24) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
